// File: rtl/gmii_rx_frame_monitor.sv
// Passive GMII receive monitor: checks preamble/SFD framing, length, rx_er and FCS, and counts frames.
// Define GMII_RX_MONITOR_CRC_CHECK_EN to include the FCS checker; otherwise the FCS is ignored.
module gmii_rx_frame_monitor #(
  parameter int COUNT_WIDTH       = 16,
  parameter int MIN_FRAME_LEN     = 64,
  parameter int MAX_FRAME_LEN     = 1518,
  parameter int LED_STRETCH_TICKS = 12500000
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic [7:0]             i_gmii_rxd,
  input  logic                   i_gmii_rx_dv,
  input  logic                   i_gmii_rx_er,
  output logic                   o_frame_valid,
  output logic                   o_frame_error,
  output logic [15:0]            o_frame_length,
  output logic [COUNT_WIDTH-1:0] o_good_count,
  output logic [COUNT_WIDTH-1:0] o_bad_count,
  output logic [COUNT_WIDTH-1:0] o_crc_error_count,
  output logic                   o_led_activity
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PREAMBLE = 2'd1;
  localparam logic [1:0] DATA     = 2'd2;
  localparam logic [1:0] DISCARD  = 2'd3;

  localparam logic [15:0] MinLen = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] MaxLen = 16'(MAX_FRAME_LEN);
  localparam int LedW = $clog2(LED_STRETCH_TICKS + 1);
  localparam logic [LedW-1:0] LedTicks = LedW'(LED_STRETCH_TICKS);
  localparam logic [LedW-1:0] LedOne = LedW'(1);
  localparam logic [COUNT_WIDTH-1:0] CntOne = COUNT_WIDTH'(1);

  logic [1:0]             state_q, state_d;
  logic [2:0]             run_q, run_d;
  logic [15:0]            len_q, len_d;
  logic                   err_q, err_d;
  logic [15:0]            frame_len_q, frame_len_d;
  logic                   valid_q, valid_d;
  logic                   error_q, error_d;
  logic [COUNT_WIDTH-1:0] good_q, good_d;
  logic [COUNT_WIDTH-1:0] bad_q, bad_d;
  logic [LedW-1:0]        led_q, led_d;
  logic                   frame_end;
  logic                   data_end;
  logic                   good_end;
  logic                   crc_ok;

  // Framing FSM; frame_end marks every return to IDLE that closes a burst, data_end only those from DATA.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    len_d     = len_q;
    err_d     = err_q;
    frame_end = 1'b0;
    data_end  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_gmii_rx_dv) begin
          if (i_gmii_rxd == 8'h55) begin
            state_d = PREAMBLE;
            run_d   = 3'd1;
          end else begin
            state_d = DISCARD;
          end
        end
      end
      PREAMBLE: begin
        if (!i_gmii_rx_dv) begin
          state_d   = IDLE;
          frame_end = 1'b1;
        end else if (i_gmii_rx_er) begin
          state_d = DISCARD;
        end else if (i_gmii_rxd == 8'hD5) begin
          state_d = DATA;
          len_d   = '0;
          err_d   = 1'b0;
        end else if (i_gmii_rxd == 8'h55 && run_q != 3'd7) begin
          run_d = run_q + 3'd1;
        end else begin
          state_d = DISCARD;
        end
      end
      DATA: begin
        if (!i_gmii_rx_dv) begin
          state_d   = IDLE;
          frame_end = 1'b1;
          data_end  = 1'b1;
        end else begin
          if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
          if (i_gmii_rx_er) err_d = 1'b1;
        end
      end
      DISCARD: begin
        if (!i_gmii_rx_dv) begin
          state_d   = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign good_end = data_end && !err_q && (len_q >= MinLen) && (len_q <= MaxLen) && crc_ok;

  always_comb begin
    valid_d     = 1'b0;
    error_d     = 1'b0;
    good_d      = good_q;
    bad_d       = bad_q;
    frame_len_d = frame_len_q;
    led_d       = led_q;
    if (data_end) frame_len_d = len_q;
    if (good_end) begin
      valid_d = 1'b1;
      if (good_q != '1) good_d = good_q + CntOne;
    end else if (frame_end) begin
      error_d = 1'b1;
      if (bad_q != '1) bad_d = bad_q + CntOne;
    end
    // A frame end reload takes priority over the stretch decrement.
    if (frame_end) led_d = LedTicks;
    else if (led_q != '0) led_d = led_q - LedOne;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      run_q       <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      frame_len_q <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      good_q      <= '0;
      bad_q       <= '0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      len_q       <= len_d;
      err_q       <= err_d;
      frame_len_q <= frame_len_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      led_q       <= led_d;
    end
  end

`ifdef GMII_RX_MONITOR_CRC_CHECK_EN
  logic [31:0]            crc_q, crc_d;
  logic [COUNT_WIDTH-1:0] crc_cnt_q, crc_cnt_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // The CRC runs over the FCS too, so an intact frame leaves the fixed residue behind.
  always_comb begin
    crc_d     = crc_q;
    crc_cnt_d = crc_cnt_q;
    if (state_q == PREAMBLE && state_d == DATA) crc_d = 32'hFFFFFFFF;
    else if (state_q == DATA && i_gmii_rx_dv) crc_d = crc_byte(crc_q, i_gmii_rxd);
    if (data_end && !crc_ok && crc_cnt_q != '1) crc_cnt_d = crc_cnt_q + CntOne;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      crc_q     <= 32'hFFFFFFFF;
      crc_cnt_q <= '0;
    end else begin
      crc_q     <= crc_d;
      crc_cnt_q <= crc_cnt_d;
    end
  end

  assign crc_ok            = (crc_q == 32'hDEBB20E3);
  assign o_crc_error_count = crc_cnt_q;
`else
  assign crc_ok            = 1'b1;
  assign o_crc_error_count = '0;
`endif

  assign o_frame_valid  = valid_q;
  assign o_frame_error  = error_q;
  assign o_frame_length = frame_len_q;
  assign o_good_count   = good_q;
  assign o_bad_count    = bad_q;
  assign o_led_activity = (led_q != '0);

endmodule

// File: tb/tb_gmii_rx_frame_monitor.sv
// Directed bench for gmii_rx_frame_monitor; expectations follow GMII_RX_MONITOR_CRC_CHECK_EN when defined.
module tb_gmii_rx_frame_monitor;

`ifdef GMII_RX_MONITOR_CRC_CHECK_EN
  localparam bit CrcEn = 1'b1;
`else
  localparam bit CrcEn = 1'b0;
`endif

  logic        clock;
  logic        resetN;
  logic [7:0]  rxData;
  logic        rxDv;
  logic        rxEr;
  logic        frameValid, frameError, ledActivity;
  logic [15:0] frameLength, goodCount, badCount, crcCount;
  logic        satValid, satError, satLed;
  logic [15:0] satLength;
  logic [1:0]  satGood, satBad, satCrc;

  int total = 0;
  int fails = 0;
  logic [15:0] expGood, expBad, expCrc;
  logic [7:0]  frameBuf [0:2047];

  gmii_rx_frame_monitor #(.LED_STRETCH_TICKS(20)) dut (
    .i_clock(clock), .i_reset_n(resetN), .i_gmii_rxd(rxData), .i_gmii_rx_dv(rxDv),
    .i_gmii_rx_er(rxEr), .o_frame_valid(frameValid), .o_frame_error(frameError),
    .o_frame_length(frameLength), .o_good_count(goodCount), .o_bad_count(badCount),
    .o_crc_error_count(crcCount), .o_led_activity(ledActivity)
  );

  gmii_rx_frame_monitor #(.COUNT_WIDTH(2), .LED_STRETCH_TICKS(20)) dutSat (
    .i_clock(clock), .i_reset_n(resetN), .i_gmii_rxd(rxData), .i_gmii_rx_dv(rxDv),
    .i_gmii_rx_er(rxEr), .o_frame_valid(satValid), .o_frame_error(satError),
    .o_frame_length(satLength), .o_good_count(satGood), .o_bad_count(satBad),
    .o_crc_error_count(satCrc), .o_led_activity(satLed)
  );

  initial clock = 1'b0;
  always #4 clock = ~clock;

  function automatic logic [31:0] crcUpdate(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else r = r >> 1;
    end
    return r;
  endfunction

  // Inputs change 1 time unit after a rising edge, so outputs are read well away from the edge.
  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    rxDv = dv; rxData = d; rxEr = er;
    @(posedge clock); #1;
  endtask

  task automatic buildFrame(input int len, input bit badFcs);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len - 4; i++) begin
      frameBuf[i] = 8'(i * 7 + 3);
      c = crcUpdate(c, frameBuf[i]);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) frameBuf[len - 4 + k] = c[8*k +: 8];
    if (badFcs) frameBuf[len - 1] = frameBuf[len - 1] ^ 8'h01;
  endtask

  // Returns in cycle N+1, one cycle after the single rx_dv=0 cycle that ends the frame.
  task automatic sendFrame(input int len, input bit badFcs, input int erAt);
    buildFrame(len, badFcs);
    repeat (7) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < len; i++) drive(1'b1, frameBuf[i], (i == erAt));
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_crc_model();
    logic [31:0] c;
    logic [7:0] digits [0:8];
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      digits[i] = 8'(8'h31 + i);
      c = crcUpdate(c, digits[i]);
    end
    total++; if (~c !== 32'hCBF43926) begin fails++; $display("[TB] FAIL crc_model actual=%08h required=cbf43926", ~c); end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) drive(1'b0, 8'h00, 1'b0);
    resetN = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    expGood = 0; expBad = 0; expCrc = 0;
    total++; if (frameValid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid actual=%0b required=0", frameValid); end
    total++; if (frameError !== 1'b0) begin fails++; $display("[TB] FAIL reset_error actual=%0b required=0", frameError); end
    total++; if (frameLength !== 16'd0) begin fails++; $display("[TB] FAIL reset_length actual=%0d required=0", frameLength); end
    total++; if (goodCount !== 16'd0) begin fails++; $display("[TB] FAIL reset_good actual=%0d required=0", goodCount); end
    total++; if (badCount !== 16'd0) begin fails++; $display("[TB] FAIL reset_bad actual=%0d required=0", badCount); end
    total++; if (crcCount !== 16'd0) begin fails++; $display("[TB] FAIL reset_crc actual=%0d required=0", crcCount); end
    total++; if (ledActivity !== 1'b0) begin fails++; $display("[TB] FAIL reset_led actual=%0b required=0", ledActivity); end
    total++; if (satGood !== 2'd0) begin fails++; $display("[TB] FAIL reset_sat_good actual=%0d required=0", satGood); end
  endtask

  task automatic test_good_frame();
    sendFrame(64, 1'b0, -1);
    expGood++;
    total++; if (frameValid !== 1'b1) begin fails++; $display("[TB] FAIL good_valid actual=%0b required=1", frameValid); end
    total++; if (frameError !== 1'b0) begin fails++; $display("[TB] FAIL good_error actual=%0b required=0", frameError); end
    total++; if (frameLength !== 16'd64) begin fails++; $display("[TB] FAIL good_length actual=%0d required=64", frameLength); end
    total++; if (goodCount !== expGood) begin fails++; $display("[TB] FAIL good_count actual=%0d required=%0d", goodCount, expGood); end
    total++; if (ledActivity !== 1'b1) begin fails++; $display("[TB] FAIL good_led actual=%0b required=1", ledActivity); end
    drive(1'b0, 8'h00, 1'b0);
    total++; if (frameValid !== 1'b0) begin fails++; $display("[TB] FAIL good_pulse_width actual=%0b required=0", frameValid); end
  endtask

  task automatic test_bad_fcs();
    logic expV;
    expV = ~CrcEn;
    sendFrame(64, 1'b1, -1);
    expBad  += CrcEn ? 16'd1 : 16'd0;
    expCrc  += CrcEn ? 16'd1 : 16'd0;
    expGood += CrcEn ? 16'd0 : 16'd1;
    total++; if (frameValid !== expV) begin fails++; $display("[TB] FAIL fcs_valid actual=%0b required=%0b", frameValid, expV); end
    total++; if (frameError !== ~expV) begin fails++; $display("[TB] FAIL fcs_error actual=%0b required=%0b", frameError, ~expV); end
    total++; if (badCount !== expBad) begin fails++; $display("[TB] FAIL fcs_bad actual=%0d required=%0d", badCount, expBad); end
    total++; if (crcCount !== expCrc) begin fails++; $display("[TB] FAIL fcs_crc actual=%0d required=%0d", crcCount, expCrc); end
    total++; if (goodCount !== expGood) begin fails++; $display("[TB] FAIL fcs_good actual=%0d required=%0d", goodCount, expGood); end
  endtask

  task automatic test_rx_error();
    sendFrame(100, 1'b0, 20);
    expBad++;
    total++; if (frameError !== 1'b1) begin fails++; $display("[TB] FAIL rxer_error actual=%0b required=1", frameError); end
    total++; if (frameValid !== 1'b0) begin fails++; $display("[TB] FAIL rxer_valid actual=%0b required=0", frameValid); end
    total++; if (frameLength !== 16'd100) begin fails++; $display("[TB] FAIL rxer_length actual=%0d required=100", frameLength); end
    total++; if (badCount !== expBad) begin fails++; $display("[TB] FAIL rxer_bad actual=%0d required=%0d", badCount, expBad); end
    total++; if (crcCount !== expCrc) begin fails++; $display("[TB] FAIL rxer_crc actual=%0d required=%0d", crcCount, expCrc); end
  endtask

  task automatic test_runt_oversize();
    sendFrame(60, 1'b0, -1);
    expBad++;
    total++; if (frameError !== 1'b1) begin fails++; $display("[TB] FAIL runt_error actual=%0b required=1", frameError); end
    total++; if (frameLength !== 16'd60) begin fails++; $display("[TB] FAIL runt_length actual=%0d required=60", frameLength); end
    sendFrame(1519, 1'b0, -1);
    expBad++;
    total++; if (frameError !== 1'b1) begin fails++; $display("[TB] FAIL over_error actual=%0b required=1", frameError); end
    total++; if (frameValid !== 1'b0) begin fails++; $display("[TB] FAIL over_valid actual=%0b required=0", frameValid); end
    total++; if (frameLength !== 16'd1519) begin fails++; $display("[TB] FAIL over_length actual=%0d required=1519", frameLength); end
    total++; if (badCount !== expBad) begin fails++; $display("[TB] FAIL over_bad actual=%0d required=%0d", badCount, expBad); end
    total++; if (crcCount !== expCrc) begin fails++; $display("[TB] FAIL over_crc actual=%0d required=%0d", crcCount, expCrc); end
    sendFrame(1518, 1'b0, -1);
    expGood++;
    total++; if (frameValid !== 1'b1) begin fails++; $display("[TB] FAIL max_valid actual=%0b required=1", frameValid); end
  endtask

  task automatic test_back_to_back();
    sendFrame(64, 1'b0, -1);
    total++; if (frameValid !== 1'b1) begin fails++; $display("[TB] FAIL b2b_first actual=%0b required=1", frameValid); end
    sendFrame(64, 1'b0, -1);
    expGood += 16'd2;
    total++; if (frameValid !== 1'b1) begin fails++; $display("[TB] FAIL b2b_second actual=%0b required=1", frameValid); end
    total++; if (goodCount !== expGood) begin fails++; $display("[TB] FAIL b2b_good actual=%0d required=%0d", goodCount, expGood); end
  endtask

  task automatic test_led_stretch();
    sendFrame(64, 1'b0, -1);
    expGood++;
    total++; if (ledActivity !== 1'b1) begin fails++; $display("[TB] FAIL led_rise actual=%0b required=1", ledActivity); end
    repeat (19) drive(1'b0, 8'h00, 1'b0);
    total++; if (ledActivity !== 1'b1) begin fails++; $display("[TB] FAIL led_last actual=%0b required=1", ledActivity); end
    drive(1'b0, 8'h00, 1'b0);
    total++; if (ledActivity !== 1'b0) begin fails++; $display("[TB] FAIL led_off actual=%0b required=0", ledActivity); end
  endtask

  task automatic test_preamble_errors();
    repeat (8) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 70; i++) drive(1'b1, 8'(i * 7 + 3), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    expBad++;
    total++; if (frameError !== 1'b1) begin fails++; $display("[TB] FAIL long_pre_error actual=%0b required=1", frameError); end
    total++; if (frameValid !== 1'b0) begin fails++; $display("[TB] FAIL long_pre_valid actual=%0b required=0", frameValid); end
    repeat (4) drive(1'b1, 8'h55, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    expBad++;
    total++; if (frameError !== 1'b1) begin fails++; $display("[TB] FAIL short_pre_error actual=%0b required=1", frameError); end
    total++; if (badCount !== expBad) begin fails++; $display("[TB] FAIL pre_bad actual=%0d required=%0d", badCount, expBad); end
    total++; if (crcCount !== expCrc) begin fails++; $display("[TB] FAIL pre_crc actual=%0d required=%0d", crcCount, expCrc); end
  endtask

  task automatic test_reset_midframe();
    buildFrame(64, 1'b0);
    repeat (7) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 30; i++) drive(1'b1, frameBuf[i], 1'b0);
    resetN = 1'b0;
    drive(1'b1, frameBuf[30], 1'b0);
    resetN = 1'b1;
    expGood = 0; expBad = 0; expCrc = 0;
    total++; if (frameValid !== 1'b0 || frameError !== 1'b0) begin fails++; $display("[TB] FAIL mid_pulses actual=%0b%0b required=00", frameValid, frameError); end
    total++; if (goodCount !== 16'd0 || badCount !== 16'd0) begin fails++; $display("[TB] FAIL mid_counts actual=%0d/%0d required=0/0", goodCount, badCount); end
    total++; if (frameLength !== 16'd0) begin fails++; $display("[TB] FAIL mid_length actual=%0d required=0", frameLength); end
    total++; if (ledActivity !== 1'b0) begin fails++; $display("[TB] FAIL mid_led actual=%0b required=0", ledActivity); end
    for (int i = 31; i < 64; i++) drive(1'b1, frameBuf[i], 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    expBad++;
    total++; if (frameError !== 1'b1 || frameValid !== 1'b0) begin fails++; $display("[TB] FAIL mid_discard_end actual=%0b%0b required=01", frameValid, frameError); end
    total++; if (badCount !== expBad) begin fails++; $display("[TB] FAIL mid_bad actual=%0d required=%0d", badCount, expBad); end
  endtask

  task automatic test_saturation();
    for (int f = 0; f < 5; f++) sendFrame(64, 1'b0, -1);
    expGood += 16'd5;
    total++; if (goodCount !== expGood) begin fails++; $display("[TB] FAIL sat_wide_good actual=%0d required=%0d", goodCount, expGood); end
    total++; if (satGood !== 2'd3) begin fails++; $display("[TB] FAIL sat_good actual=%0d required=3", satGood); end
    total++; if (satBad !== 2'd1) begin fails++; $display("[TB] FAIL sat_bad actual=%0d required=1", satBad); end
  endtask

  initial begin
    resetN = 1'b0; rxDv = 1'b0; rxData = 8'h00; rxEr = 1'b0;
    @(posedge clock); #1;
    test_crc_model();
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_rx_error();
    test_runt_oversize();
    test_back_to_back();
    test_led_stretch();
    test_preamble_errors();
    test_reset_midframe();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, fails);
    $finish;
  end

endmodule
